// File: rtl/alu_lock_arbiter_pkg.sv
// alu_lock_arbiter_pkg: shared types and helpers for the ALU lock arbiter
package alu_lock_arbiter_pkg;
  localparam int IDX_W = 8;
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } alu_owner_t;
  function automatic int w_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int ALU_W = w_of(2);
  localparam int SIC_W = w_of(4);
  // Shifting the difference left puts the id-width sign bit at bit 31, so wrap is handled for any w.
  function automatic logic is_older(input logic [31:0] id_a, input logic [31:0] id_b,
                                    input int idx_a, input int idx_b, input int w = 8);
    logic [31:0] d;
    d = (id_a - id_b) << (32 - w);
    return d[31] || (d == '0 && idx_a < idx_b);
  endfunction
endpackage

// File: rtl/alu_lock_arbiter_age_select.sv
// alu_age_select: combinational pick of the oldest candidate in a mask
module alu_age_select
  import alu_lock_arbiter_pkg::*;
#(
  parameter  int NUM_SICS = 4,
  parameter  int ID_WIDTH = 8,
  localparam int SEL_W    = w_of(NUM_SICS)
) (
  input  logic [NUM_SICS-1:0]          mask_i,
  input  logic [NUM_SICS*ID_WIDTH-1:0] ids_i,
  output logic                         valid_o,
  output logic [SEL_W-1:0]             idx_o
);
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < NUM_SICS; i++)
      if (mask_i[i] && (!valid_o || is_older(32'(ids_i[i*ID_WIDTH +: ID_WIDTH]),
                                             32'(ids_i[int'(idx_o)*ID_WIDTH +: ID_WIDTH]),
                                             i, int'(idx_o), ID_WIDTH))) begin
        valid_o = 1'b1;
        idx_o   = SEL_W'(i);
      end
  end
endmodule

// File: rtl/alu_lock_arbiter.sv
// alu_lock_arbiter: age-ordered lock allocation of a shared ALU pool to SIC units
module alu_lock_arbiter
  import alu_lock_arbiter_pkg::*;
#(
  parameter  int NUM_SICS = 4,
  parameter  int NUM_ALUS = 2,
  parameter  int ID_WIDTH = 8,
  localparam int AW       = w_of(NUM_ALUS),
  localparam int SW       = w_of(NUM_SICS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SICS-1:0]          req,
  input  logic [NUM_SICS*ID_WIDTH-1:0] req_issue_id,
  input  logic [NUM_SICS-1:0]          release_lock,
  output logic [NUM_SICS-1:0]          grant,
  output logic [NUM_SICS*AW-1:0]       alu_sel,
  output logic [NUM_ALUS-1:0]          owner_valid,
  output logic [NUM_ALUS*SW-1:0]       owner_idx
);
  alu_owner_t          own_q [NUM_ALUS];
  alu_owner_t          own_d [NUM_ALUS];
  logic [NUM_SICS-1:0] owns, cand;
  logic [NUM_SICS-1:0] mask [NUM_ALUS];
  logic [NUM_ALUS-1:0] sel_v;
  logic [SW-1:0]       sel_idx [NUM_ALUS];
  int                  cnt;

  always_comb begin
    owns    = '0;
    alu_sel = '0;
    for (int k = 0; k < NUM_ALUS; k++)
      for (int i = 0; i < NUM_SICS; i++)
        if (own_q[k].valid && own_q[k].idx == IDX_W'(i)) begin
          owns[i] = 1'b1;
          if (req[i]) alu_sel[i*AW +: AW] = AW'(k);
        end
  end

  assign grant   = req & owns;
  assign cand    = req & ~release_lock & ~owns;
  assign mask[0] = cand;

  // Stage j serves the j-th lowest free ALU; later stages skip earlier picks.
  for (genvar j = 0; j < NUM_ALUS; j++) begin : g_sel
    alu_age_select #(.NUM_SICS(NUM_SICS), .ID_WIDTH(ID_WIDTH)) u_sel (
      .mask_i (mask[j]),
      .ids_i  (req_issue_id),
      .valid_o(sel_v[j]),
      .idx_o  (sel_idx[j])
    );
    if (j + 1 < NUM_ALUS) begin : g_nx
      assign mask[j+1] = mask[j] & ~(NUM_SICS'(sel_v[j]) << sel_idx[j]);
    end
  end

  always_comb begin
    cnt = 0;
    for (int k = 0; k < NUM_ALUS; k++) begin
      own_d[k] = own_q[k];
      if (own_q[k].valid) begin
        if (release_lock[own_q[k].idx[SW-1:0]] || !req[own_q[k].idx[SW-1:0]]) own_d[k] = '0;
      end else begin
        if (sel_v[cnt]) own_d[k] = '{valid: 1'b1, idx: IDX_W'(sel_idx[cnt])};
        cnt++;
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) own_q <= '{default: '0};
    else     own_q <= own_d;

  for (genvar k = 0; k < NUM_ALUS; k++) begin : g_out
    assign owner_valid[k]          = own_q[k].valid;
    assign owner_idx[k*SW +: SW]   = own_q[k].idx[SW-1:0];
  end
endmodule

// File: tb/tb_alu_lock_arbiter.sv
// tb_alu_lock_arbiter: directed scoreboard bench for alu_lock_arbiter (4 SICs, 2 ALUs)
module tb_alu_lock_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] ids = '0;
  logic [3:0]  release_lock = '0;
  logic [3:0]  grant;
  logic [3:0]  alu_sel;
  logic [1:0]  owner_valid;
  logic [3:0]  owner_idx;

  typedef struct {
    logic [13:0] e;
    string       nm;
  } exp_t;
  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_lock_arbiter #(.NUM_SICS(4), .NUM_ALUS(2), .ID_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_issue_id(ids),
    .release_lock(release_lock),
    .grant       (grant),
    .alu_sel     (alu_sel),
    .owner_valid (owner_valid),
    .owner_idx   (owner_idx)
  );

  always #5 clk = ~clk;

  // e = {grant, alu_sel, owner_valid, owner_idx}, observed in the cycle the inputs are applied
  task automatic step(input logic rs, input logic [3:0] r, input logic [3:0] rl,
                      input logic [31:0] id, input logic [13:0] e, input string nm);
    @(posedge clk);
    #1;
    rst = rs;
    req = r;
    release_lock = rl;
    ids = id;
    q.push_back('{e: e, nm: nm});
  endtask

  initial begin : monitor
    exp_t x;
    logic [13:0] act;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        x = q.pop_front();
        act = {grant, alu_sel, owner_valid, owner_idx};
        n_cmp++;
        if (act !== x.e) begin
          n_bad++;
          $display("FAIL %s: got g=%b sel=%b ov=%b oi=%b, want g=%b sel=%b ov=%b oi=%b",
                   x.nm, act[13:10], act[9:6], act[5:4], act[3:0],
                   x.e[13:10], x.e[9:6], x.e[5:4], x.e[3:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] id_a, id_b, id_c, id_d, id_e;
    id_a = {8'd0, 8'd0, 8'd0, 8'd5};
    id_b = {8'd4, 8'd7, 8'd3, 8'd9};
    id_c = {8'd0, 8'd0, 8'd2, 8'd250};
    id_d = {8'd0, 8'd3, 8'd2, 8'd1};
    id_e = {8'd30, 8'd5, 8'd20, 8'd10};
    step(1, 4'b0000, 4'b0000, id_a, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "reset0");
    step(1, 4'b0001, 4'b0000, id_a, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "reset_req");
    // single requester
    step(0, 4'b0001, 4'b0000, id_a, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "single_first");
    step(0, 4'b0001, 4'b0000, id_a, {4'b0001, 4'b0000, 2'b01, 4'b0000}, "single_grant");
    step(0, 4'b0001, 4'b0000, id_a, {4'b0001, 4'b0000, 2'b01, 4'b0000}, "single_hold");
    step(0, 4'b0001, 4'b0001, id_a, {4'b0001, 4'b0000, 2'b01, 4'b0000}, "single_rel");
    step(0, 4'b0000, 4'b0000, id_a, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "single_freed");
    // age priority and back-to-back reuse
    step(0, 4'b1111, 4'b0000, id_b, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "age_first");
    step(0, 4'b1111, 4'b0000, id_b, {4'b1010, 4'b1000, 2'b11, 4'b1101}, "age_grant");
    step(0, 4'b1111, 4'b0000, id_b, {4'b1010, 4'b1000, 2'b11, 4'b1101}, "age_wait");
    step(0, 4'b1111, 4'b0010, id_b, {4'b1010, 4'b1000, 2'b11, 4'b1101}, "age_rel");
    step(0, 4'b1101, 4'b0000, id_b, {4'b1000, 4'b1000, 2'b10, 4'b1100}, "reuse_gap");
    step(0, 4'b1101, 4'b0000, id_b, {4'b1100, 4'b1000, 2'b11, 4'b1110}, "reuse_sic2");
    step(0, 4'b0000, 4'b0000, id_b, {4'b0000, 4'b0000, 2'b11, 4'b1110}, "age_drop");
    step(0, 4'b0000, 4'b0000, id_b, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "age_idle");
    // wrap-around with a single free ALU
    step(0, 4'b1000, 4'b0000, id_c, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "wrap_fill");
    step(0, 4'b1000, 4'b0000, id_c, {4'b1000, 4'b0000, 2'b01, 4'b0011}, "wrap_own3");
    step(0, 4'b1011, 4'b0000, id_c, {4'b1000, 4'b0000, 2'b01, 4'b0011}, "wrap_first");
    step(0, 4'b1011, 4'b0000, id_c, {4'b1001, 4'b0001, 2'b11, 4'b0011}, "wrap_grant");
    step(0, 4'b0000, 4'b0000, id_c, {4'b0000, 4'b0000, 2'b11, 4'b0011}, "wrap_drop");
    step(0, 4'b0000, 4'b0000, id_c, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "wrap_idle");
    // abort before and after grant
    step(0, 4'b0011, 4'b0000, id_d, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "abort_first");
    step(0, 4'b0111, 4'b0000, id_d, {4'b0011, 4'b0010, 2'b11, 4'b0100}, "abort_full");
    step(0, 4'b0111, 4'b0000, id_d, {4'b0011, 4'b0010, 2'b11, 4'b0100}, "abort_wait");
    step(0, 4'b0011, 4'b0100, id_d, {4'b0011, 4'b0010, 2'b11, 4'b0100}, "abort_nonown");
    step(0, 4'b0011, 4'b0000, id_d, {4'b0011, 4'b0010, 2'b11, 4'b0100}, "abort_nochg");
    step(0, 4'b0010, 4'b0001, id_d, {4'b0010, 4'b0010, 2'b11, 4'b0100}, "abort_owner");
    step(0, 4'b0010, 4'b0000, id_d, {4'b0010, 4'b0010, 2'b10, 4'b0100}, "abort_freed");
    step(0, 4'b0110, 4'b0100, id_d, {4'b0010, 4'b0010, 2'b10, 4'b0100}, "relreq_same");
    step(0, 4'b0110, 4'b0000, id_d, {4'b0010, 4'b0010, 2'b10, 4'b0100}, "relreq_skip");
    step(0, 4'b0110, 4'b0000, id_d, {4'b0110, 4'b0010, 2'b11, 4'b0110}, "relreq_grant");
    step(0, 4'b0000, 4'b0000, id_d, {4'b0000, 4'b0000, 2'b11, 4'b0110}, "abort_drop");
    step(0, 4'b0000, 4'b0000, id_d, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "abort_idle");
    // reset mid-lock
    step(0, 4'b0011, 4'b0000, id_e, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "rst_first");
    step(0, 4'b0011, 4'b0000, id_e, {4'b0011, 4'b0010, 2'b11, 4'b0100}, "rst_owned");
    step(1, 4'b1111, 4'b0000, id_e, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "rst_async");
    step(1, 4'b1111, 4'b0000, id_e, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "rst_held");
    step(0, 4'b1111, 4'b0000, id_e, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "rst_release");
    step(0, 4'b1111, 4'b0000, id_e, {4'b0101, 4'b0001, 2'b11, 4'b0010}, "rst_regrant");
    step(0, 4'b0000, 4'b0000, id_e, {4'b0000, 4'b0000, 2'b11, 4'b0010}, "rst_drop");
    step(0, 4'b0000, 4'b0000, id_e, {4'b0000, 4'b0000, 2'b00, 4'b0000}, "rst_idle");
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_lock_arbiter.md
Name: alu_lock_arbiter

Overview:
- Shares a pool of NUM_ALUS ALUs among NUM_SICS SIC execute units.
- Each SIC raises a lock request tagged with its issue_id. The arbiter grants the oldest requesters first (modular issue_id age) and holds each lock until the owner releases it.
- Drives the per-SIC grant, the per-SIC ALU select, and the per-ALU owner map that steers the ALU operand/result crossbar.

Parameters:
- NUM_SICS, 4, number of requesting SIC units.
- NUM_ALUS, 2, number of shared ALUs (1..NUM_SICS).
- ID_WIDTH, 8, issue_id width; ids wrap modulo 2^ID_WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- req  input  NUM_SICS  per-SIC lock request, level, held until commit/abort
- req_issue_id  input  NUM_SICS*ID_WIDTH  per-SIC issue_id, SIC i at bits [i*ID_WIDTH +: ID_WIDTH]
- release_lock  input  NUM_SICS  per-SIC one-cycle release pulse
- grant  output  NUM_SICS  per-SIC lock held and req high
- alu_sel  output  NUM_SICS*ALU_W  per-SIC index of the owned ALU (0 when not granted)
- owner_valid  output  NUM_ALUS  ALU k currently locked
- owner_idx  output  NUM_ALUS*SIC_W  owning SIC index per ALU (0 when free)

Behaviour:
- ALU_W = max(1,clog2(NUM_ALUS)); SIC_W = max(1,clog2(NUM_SICS)).
- Clock and reset:
  - Single clock domain.
  - rst asserted at any time, including mid-lock, asynchronously clears all owner registers.
  - While rst is high, grant, alu_sel, owner_valid and owner_idx are all 0.
- State: per ALU k, a registered pair {own_v[k], own_i[k]}. No other state.
- Age order:
  - SIC a is older than SIC b iff (id_a - id_b) mod 2^ID_WIDTH, read as signed, is negative.
  - Equal ids: lower SIC index is older.
  - Correctness requires in-flight ids to span < 2^(ID_WIDTH-1).
- Candidates: SIC i with req[i]=1, release_lock[i]=0, and not currently an owner.
- Allocation, each cycle:
  - F = number of ALUs with own_v=0.
  - Select up to F candidates in age order (oldest first).
  - The j-th oldest selected candidate takes the j-th lowest-index free ALU.
  - Owner registers are written at the clock edge.
- Latency:
  - req first high in cycle N with a free ALU -> grant high in cycle N+1. This is the minimum.
  - No grant is issued in the cycle a request first appears.
- Grant output:
  - grant[i] = req[i] AND (some k has own_v[k] and own_i[k]==i). Combinational from registers.
  - A dropped req removes grant in the same cycle.
  - alu_sel[i] = that k.
- Lock hold: once owned, the lock persists across stalls (rf/ecr not ready) until it is freed.
- Freeing: ALU k's owner register clears at the edge ending a cycle where its owner has release_lock=1 or req=0. Both events may coincide; the result is the same.
- Reuse: a freed ALU may be allocated in the following cycle, not the same cycle (no combinational bypass).
- Release without lock: release_lock from a non-owner (e.g. abort before grant) is ignored, and that SIC is not a candidate that cycle.
- Request cap: at most one ALU per SIC; a SIC already owning an ALU never gets a second.
- Contention: candidates > F -> the youngest wait. There is no round-robin, because age order guarantees forward progress.
- Invariants:
  - Owners are distinct across ALUs.
  - popcount(grant) <= NUM_ALUS.
  - grant[i] implies req[i].

Decomposition:
- Shared package holds:
  - age compare function is_older(id_a, id_b, idx_a, idx_b);
  - ALU_W and SIC_W helper localparams;
  - alu_owner_t struct {valid, idx}.
- One natural sub-module, alu_age_select: combinational pick of the oldest candidate from a mask. The top instantiates NUM_ALUS of these in cascade, each masking out earlier picks.
- Owner registers, freeing logic and grant/alu_sel decode stay in the top.

Test Plan:
- Single requester: NUM_ALUS=2, SIC0 req with id=5 at cycle 1 -> grant[0]=1, alu_sel[0]=0 at cycle 2. Release pulse at cycle 6 -> owner_valid[0]=0 at cycle 7.
- Age priority: SICs 0..3 request simultaneously with ids 9,3,7,4 -> SIC1 gets ALU0 and SIC3 gets ALU1. SICs 0 and 2 stay ungranted until a release; then SIC2 (id 7) wins before SIC0 (id 9).
- Wrap-around: ids 250 (SIC0) and 2 (SIC1), one ALU -> SIC0 granted first.
- Abort: SIC2 drops req at cycle 4 with release pulse, never granted -> no owner change, no grant glitch. Abort while owning -> grant falls in the same cycle and the ALU is free the next cycle.
- Back-to-back reuse: owner releases at cycle N while another SIC waits -> waiter granted at cycle N+2. No cycle has two owners on one ALU.
- Reset mid-lock: assert rst asynchronously while both ALUs are owned -> all outputs 0 immediately. After deassert, pending reqs are granted after one cycle in age order.
